// File: rtl/id_ex_pipe_if.sv
// ID/EX pipeline boundary: ID-side inputs, registered EX-side copies,
// and the hazard and status signals that flow back toward IF/ID.
interface id_ex_pipe_if;
  logic        id_valid;
  logic [6:0]  id_opcode;
  logic [11:0] id_ctrl;
  logic [31:0] id_pc;
  logic [31:0] id_rd1;
  logic [31:0] id_rd2;
  logic [31:0] id_imm;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;
  logic        flush;

  logic        ex_valid;
  logic [11:0] ex_ctrl;
  logic [31:0] ex_pc;
  logic [31:0] ex_rd1;
  logic [31:0] ex_rd2;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_funct3;
  logic [6:0]  ex_funct7;

  logic        stall_id;
  logic        halted;
  logic [15:0] stall_count;

  // Driver side: the ID stage / surrounding pipeline
  modport master (
    output id_valid, id_opcode, id_ctrl, id_pc, id_rd1, id_rd2, id_imm,
           id_rs1, id_rs2, id_rd, id_funct3, id_funct7, flush,
    input  ex_valid, ex_ctrl, ex_pc, ex_rd1, ex_rd2, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7,
           stall_id, halted, stall_count
  );

  // Register side: the ID/EX pipeline register itself
  modport slave (
    input  id_valid, id_opcode, id_ctrl, id_pc, id_rd1, id_rd2, id_imm,
           id_rs1, id_rs2, id_rd, id_funct3, id_funct7, flush,
    output ex_valid, ex_ctrl, ex_pc, ex_rd1, ex_rd2, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7,
           stall_id, halted, stall_count
  );
endinterface

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use hazard detection, flush squash,
// sticky HALT and a saturating stall-cycle counter.
// CNT_W sets the internal counter width (<= 16); the port is zero-extended.
module id_ex_pipe #(
  parameter int unsigned CNT_W = 16
) (
  input logic         clk,
  input logic         reset,
  id_ex_pipe_if.slave bus
);
  localparam int unsigned BUNDLE_W = 165;
  localparam logic [6:0]  OP_HALT  = 7'b1111111;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                ex_valid_reg;
  logic [BUNDLE_W-1:0] ex_bundle_reg;
  logic                halted_reg;
  logic [CNT_W-1:0]    stall_cnt_reg;

  logic [BUNDLE_W-1:0] id_bundle;
  logic                stall;
  logic                is_halt;
  logic                bubble;

  // All ID payload fields travel as one vector so a bubble clears them together
  assign id_bundle = {bus.id_ctrl, bus.id_pc, bus.id_rd1, bus.id_rd2, bus.id_imm,
                      bus.id_rs1, bus.id_rs2, bus.id_rd, bus.id_funct3, bus.id_funct7};

  // Load-use hazard: EX load writes a register the ID instruction reads.
  // rs2 is compared for every opcode; x0 is never a hazard.
  always_comb begin
    stall = bus.id_valid && ex_valid_reg && ex_bundle_reg[BUNDLE_W-4] &&
            (bus.ex_rd != 5'd0) &&
            ((bus.ex_rd == bus.id_rs1) || (bus.ex_rd == bus.id_rs2));
  end

  assign is_halt = bus.id_valid && (bus.id_opcode == OP_HALT);
  // A HALT in ID is itself squashed: it never reaches EX
  assign bubble  = bus.flush || stall || halted_reg || !bus.id_valid || is_halt;

  // EX-stage register: bubble or capture, in priority order
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_reg  <= 1'b0;
      ex_bundle_reg <= '0;
    end else if (bubble) begin
      ex_valid_reg  <= 1'b0;
      ex_bundle_reg <= '0;
    end else begin
      ex_valid_reg  <= 1'b1;
      ex_bundle_reg <= id_bundle;
    end
  end

  // Sticky halt: only set when nothing of higher priority claims the edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halted_reg <= 1'b0;
    end else if (!bus.flush && !stall && is_halt) begin
      halted_reg <= 1'b1;
    end
  end

  // Stall counter: counts un-flushed stall edges, holds at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_reg <= '0;
    end else if (stall && !bus.flush && (stall_cnt_reg != CNT_MAX)) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign bus.ex_valid = ex_valid_reg;
  assign {bus.ex_ctrl, bus.ex_pc, bus.ex_rd1, bus.ex_rd2, bus.ex_imm,
          bus.ex_rs1, bus.ex_rs2, bus.ex_rd, bus.ex_funct3, bus.ex_funct7} = ex_bundle_reg;
  assign bus.stall_id    = stall;
  assign bus.halted      = halted_reg;
  assign bus.stall_count = 16'(stall_cnt_reg);
endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe: a full-width instance and a 3-bit-counter
// instance share the same ID stimulus so saturation is reached quickly.
module tb_id_ex_pipe;
  localparam logic [6:0]  OP_HALT = 7'h7F;
  localparam logic [6:0]  OP_LW   = 7'h03;
  localparam logic [6:0]  OP_ADD  = 7'h33;
  localparam logic [6:0]  OP_SW   = 7'h23;
  localparam logic [6:0]  OP_BEQ  = 7'h63;
  localparam logic [11:0] C_LW    = 12'hF00;
  localparam logic [11:0] C_ADD   = 12'h200;
  localparam logic [11:0] C_SW    = 12'h880;
  localparam logic [11:0] C_BEQ   = 12'h001;
  localparam int          SMAX    = 7;

  logic clk;
  logic reset;

  id_ex_pipe_if bus ();
  id_ex_pipe_if bus_s ();

  id_ex_pipe #(.CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  id_ex_pipe #(.CNT_W(3))  dut_s (.clk(clk), .reset(reset), .bus(bus_s.slave));

  assign bus_s.id_valid  = bus.id_valid;
  assign bus_s.id_opcode = bus.id_opcode;
  assign bus_s.id_ctrl   = bus.id_ctrl;
  assign bus_s.id_pc     = bus.id_pc;
  assign bus_s.id_rd1    = bus.id_rd1;
  assign bus_s.id_rd2    = bus.id_rd2;
  assign bus_s.id_imm    = bus.id_imm;
  assign bus_s.id_rs1    = bus.id_rs1;
  assign bus_s.id_rs2    = bus.id_rs2;
  assign bus_s.id_rd     = bus.id_rd;
  assign bus_s.id_funct3 = bus.id_funct3;
  assign bus_s.id_funct7 = bus.id_funct7;
  assign bus_s.flush     = bus.flush;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic         v;
    logic [164:0] f;
    logic         h;
    logic [15:0]  c;
    logic [15:0]  cs;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_txn    = 0;

  // Reference model state
  logic         m_valid;
  logic [164:0] m_f;
  logic [4:0]   m_rd;
  logic         m_load;
  logic         m_halted;
  int           m_cnt;
  int           m_cnt_s;

  task automatic check(input string tag, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [164:0] ex_act();
    return {bus.ex_ctrl, bus.ex_pc, bus.ex_rd1, bus.ex_rd2, bus.ex_imm,
            bus.ex_rs1, bus.ex_rs2, bus.ex_rd, bus.ex_funct3, bus.ex_funct7};
  endfunction

  function automatic logic [164:0] ex_act_s();
    return {bus_s.ex_ctrl, bus_s.ex_pc, bus_s.ex_rd1, bus_s.ex_rd2, bus_s.ex_imm,
            bus_s.ex_rs1, bus_s.ex_rs2, bus_s.ex_rd, bus_s.ex_funct3, bus_s.ex_funct7};
  endfunction

  task automatic model_clear();
    m_valid = 1'b0; m_f = '0; m_rd = '0; m_load = 1'b0;
    m_halted = 1'b0; m_cnt = 0; m_cnt_s = 0;
  endtask

  // One cycle: drive ID at the falling edge, check stall_id, predict, then
  // compare the registered outputs just after the rising edge.
  task automatic step(input logic v, input logic [6:0] op, input logic [11:0] ctrl,
                      input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic fl);
    logic [31:0] rd1, rd2, imm;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        exp_stall, halt_in, bub;
    exp_t        e, got;
    rd1 = $urandom; rd2 = $urandom; imm = $urandom;
    f3 = 3'($urandom); f7 = 7'($urandom);
    @(negedge clk);
    bus.id_valid = v; bus.id_opcode = op; bus.id_ctrl = ctrl; bus.id_pc = pc;
    bus.id_rd1 = rd1; bus.id_rd2 = rd2; bus.id_imm = imm;
    bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd;
    bus.id_funct3 = f3; bus.id_funct7 = f7; bus.flush = fl;
    #1;
    exp_stall = v && m_valid && m_load && (m_rd != 5'd0) && (m_rd == rs1 || m_rd == rs2);
    check("stall_id", 192'(bus.stall_id), 192'(exp_stall));
    check("stall_id_s", 192'(bus_s.stall_id), 192'(exp_stall));
    halt_in = v && (op == OP_HALT);
    bub = fl || exp_stall || m_halted || !v || halt_in;
    if (exp_stall && !fl) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt_s < SMAX) m_cnt_s++;
    end
    if (!fl && !exp_stall && halt_in) m_halted = 1'b1;
    if (bub) begin
      m_valid = 1'b0; m_f = '0; m_rd = '0; m_load = 1'b0;
    end else begin
      m_valid = 1'b1; m_f = {ctrl, pc, rd1, rd2, imm, rs1, rs2, rd, f3, f7};
      m_rd = rd; m_load = ctrl[8];
    end
    e.v = m_valid; e.f = m_f; e.h = m_halted; e.c = 16'(m_cnt); e.cs = 16'(m_cnt_s);
    q.push_back(e);
    @(posedge clk);
    #1;
    got = q.pop_front();
    n_txn++;
    $display("txn %0d v=%0b op=%h rs1=%0d rs2=%0d rd=%0d fl=%0b -> ex_valid=%0b halted=%0b cnt=%0d",
             n_txn, v, op, rs1, rs2, rd, fl, bus.ex_valid, bus.halted, bus.stall_count);
    check("ex_valid", 192'(bus.ex_valid), 192'(got.v));
    check("ex_fields", 192'(ex_act()), 192'(got.f));
    check("halted", 192'(bus.halted), 192'(got.h));
    check("stall_count", 192'(bus.stall_count), 192'(got.c));
    check("ex_fields_s", 192'(ex_act_s()), 192'(got.f));
    check("stall_count_s", 192'(bus_s.stall_count), 192'(got.cs));
  endtask

  // Reset pulse between edges; outputs must clear before the next edge
  task automatic async_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_ex_valid", 192'(bus.ex_valid), 192'(0));
    check("rst_fields", 192'(ex_act()), 192'(0));
    check("rst_halted", 192'(bus.halted), 192'(0));
    check("rst_count", 192'(bus.stall_count), 192'(0));
    check("rst_count_s", 192'(bus_s.stall_count), 192'(0));
    check("rst_stall_id", 192'(bus.stall_id), 192'(0));
    #1 reset = 1'b0;
    model_clear();
  endtask

  initial begin
    int k;
    reset = 1'b1;
    bus.id_valid = 1'b0; bus.id_opcode = '0; bus.id_ctrl = '0; bus.id_pc = '0;
    bus.id_rd1 = '0; bus.id_rd2 = '0; bus.id_imm = '0; bus.id_rs1 = '0;
    bus.id_rs2 = '0; bus.id_rd = '0; bus.id_funct3 = '0; bus.id_funct7 = '0;
    bus.flush = 1'b0;
    model_clear();
    #12;
    check("init_ex_valid", 192'(bus.ex_valid), 192'(0));
    check("init_fields", 192'(ex_act()), 192'(0));
    check("init_halted", 192'(bus.halted), 192'(0));
    check("init_count", 192'(bus.stall_count), 192'(0));
    @(negedge clk);
    reset = 1'b0;

    // Plain capture
    step(1, OP_ADD, 12'h600, 32'h10, 5'd1, 5'd2, 5'd3, 0);
    check("cap_ctrl", 192'(bus.ex_ctrl), 192'(12'h600));
    check("cap_pc", 192'(bus.ex_pc), 192'(32'h10));
    check("cap_rd", 192'(bus.ex_rd), 192'(5'd3));

    // Load-use on rs2: stall, bubble, then the held instruction is captured
    step(1, OP_LW, C_LW, 32'h14, 5'd1, 5'd0, 5'd5, 0);
    step(1, OP_ADD, C_ADD, 32'h18, 5'd7, 5'd5, 5'd6, 0);
    check("lu_count", 192'(bus.stall_count), 192'(1));
    step(1, OP_ADD, C_ADD, 32'h18, 5'd7, 5'd5, 5'd6, 0);
    check("lu_capture_pc", 192'(bus.ex_pc), 192'(32'h18));

    // x0 destination never stalls
    step(1, OP_LW, C_LW, 32'h1C, 5'd1, 5'd2, 5'd0, 0);
    step(1, OP_ADD, C_ADD, 32'h20, 5'd0, 5'd0, 5'd4, 0);

    // Flush beats load-use and HALT together
    step(1, OP_LW, C_LW, 32'h24, 5'd1, 5'd2, 5'd5, 0);
    step(1, OP_HALT, C_ADD, 32'h28, 5'd5, 5'd5, 5'd1, 1);
    check("fl_halted", 192'(bus.halted), 192'(0));

    // Halt is sticky until reset
    step(1, OP_HALT, 12'h000, 32'h2C, 5'd0, 5'd0, 5'd0, 0);
    for (int i = 0; i < 5; i++)
      step(1, OP_ADD, C_ADD, 32'h30 + 32'(i * 4), 5'd1, 5'd2, 5'd3, 0);
    async_reset();
    step(1, OP_ADD, C_ADD, 32'h40, 5'd1, 5'd2, 5'd3, 0);

    // Back-to-back dependent loads: every other edge is a stall
    step(1, OP_LW, C_LW, 32'h44, 5'd1, 5'd2, 5'd5, 0);
    for (int i = 0; i < 40; i++)
      step(1, OP_LW, C_LW, 32'h48, 5'd5, 5'd9, 5'd5, 0);
    check("sat_s", 192'(bus_s.stall_count), 192'(SMAX));
    // EX now holds the load again, ID hazard pending: reset mid-stall
    async_reset();

    // Random traffic with occasional flush, HALT and reset
    for (int i = 0; i < 240; i++) begin
      logic [6:0]  op;
      logic [11:0] ct;
      k = $urandom_range(0, 99);
      if (k < 35)      begin op = OP_LW;  ct = C_LW;  end
      else if (k < 65) begin op = OP_ADD; ct = C_ADD; end
      else if (k < 80) begin op = OP_SW;  ct = C_SW;  end
      else if (k < 98) begin op = OP_BEQ; ct = C_BEQ; end
      else             begin op = OP_HALT; ct = 12'h000; end
      step(($urandom_range(0, 99) < 85), op, ct, $urandom,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 99) < 10));
      if (i % 60 == 59) async_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
